alu_cmp_pipe: RTL and testbench

- Pipelined, parametrised compare/select unit; successor to the combinational SLTU block.
- Supports signed and unsigned set-less-than, equality and min/max selection on WIDTH-bit operands.
- Adds a valid/ready handshake, a configurable latency and a tag passthrough.
- Sits in the execute stage beside the adder/shifter; the issue logic drives it and the writeback arbiter drains it.

---
 rtl/alu_cmp_pipe.sv | 88 ++++++++
 tb/tb_alu_cmp_pipe.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmp_pipe.sv
// Pipelined compare/select unit (SLT/SLTU/EQ/NE/SGE/SGEU, signed/unsigned MIN/MAX) with tag passthrough.
// Latency LAT cycles; global stall: every stage holds while the output is stalled, in_ready = !out_valid || out_ready.
module alu_cmp_pipe #(
   parameter int WIDTH = 32,
   parameter int LAT   = 2,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] rs1,
   input  logic [WIDTH-1:0] rs2,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] rd,
   output logic [TAG_W-1:0] out_tag,
   output logic             illegal
);

   typedef struct packed {
      logic             vld;
      logic             ill;
      logic [TAG_W-1:0] tag;
      logic [WIDTH-1:0] dat;
   } stage_t;

   localparam logic [WIDTH-2:0] ZPAD = '0;

   stage_t     stg [LAT];
   stage_t     nxt;
   logic       advance;
   logic       lt_s;
   logic       lt_u;
   logic       eq;

   assign lt_s = $signed(rs1) < $signed(rs2);
   assign lt_u = rs1 < rs2;
   assign eq   = rs1 == rs2;

   assign advance  = !stg[LAT-1].vld || out_ready;
   assign in_ready = advance;

   // Ties on min/max resolve to rs1.
   always_comb begin
      nxt     = '0;
      nxt.vld = in_valid;
      nxt.tag = in_tag;
      case (op)
         4'd0:    nxt.dat = {ZPAD, lt_s};
         4'd1:    nxt.dat = {ZPAD, lt_u};
         4'd2:    nxt.dat = {ZPAD, eq};
         4'd3:    nxt.dat = {ZPAD, !eq};
         4'd4:    nxt.dat = {ZPAD, !lt_s};
         4'd5:    nxt.dat = {ZPAD, !lt_u};
         4'd6:    nxt.dat = (lt_s || eq) ? rs1 : rs2;
         4'd7:    nxt.dat = lt_s ? rs2 : rs1;
         4'd8:    nxt.dat = (lt_u || eq) ? rs1 : rs2;
         4'd9:    nxt.dat = lt_u ? rs2 : rs1;
         default: nxt.ill = 1'b1;
      endcase
      // Bubbles carry all-zero payload so rd reads 0 whenever out_valid is low.
      if (!in_valid) begin
         nxt = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < LAT; i++) begin
            stg[i] <= '0;
         end
      end else if (advance) begin
         stg[0] <= nxt;
         for (int i = 1; i < LAT; i++) begin
            stg[i] <= stg[i-1];
         end
      end
   end

   assign out_valid = stg[LAT-1].vld;
   assign rd        = stg[LAT-1].dat;
   assign out_tag   = stg[LAT-1].tag;
   assign illegal   = stg[LAT-1].ill;

endmodule

// File: tb/tb_alu_cmp_pipe.sv
// Bench for alu_cmp_pipe: directed vector table, latency/backpressure/reset sequences,
// a WIDTH=8/LAT=1 instance, and a randomized run scored against a queue-based model.
module tb_alu_cmp_pipe;

   localparam int WIDTH = 32;
   localparam int LAT   = 2;
   localparam int TAG_W = 5;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       op;
   logic [WIDTH-1:0] rs1;
   logic [WIDTH-1:0] rs2;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] rd;
   logic [TAG_W-1:0] out_tag;
   logic             illegal;

   logic             s_in_valid;
   logic             s_in_ready;
   logic [3:0]       s_op;
   logic [7:0]       s_rs1;
   logic [7:0]       s_rs2;
   logic [TAG_W-1:0] s_in_tag;
   logic             s_out_valid;
   logic             s_out_ready;
   logic [7:0]       s_rd;
   logic [TAG_W-1:0] s_out_tag;
   logic             s_illegal;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_rd;
      logic        exp_ill;
   } vec_t;

   typedef struct {
      logic [31:0] rd;
      logic [4:0]  tag;
      logic        ill;
   } exp_t;

   vec_t vt [10];
   exp_t q [$];
   int   bp_tag [9];

   alu_cmp_pipe #(.WIDTH(WIDTH), .LAT(LAT), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
      .rs1(rs1), .rs2(rs2), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
      .rd(rd), .out_tag(out_tag), .illegal(illegal)
   );

   alu_cmp_pipe #(.WIDTH(8), .LAT(1), .TAG_W(TAG_W)) dut_s (
      .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .op(s_op),
      .rs1(s_rs1), .rs2(s_rs2), .in_tag(s_in_tag), .out_valid(s_out_valid),
      .out_ready(s_out_ready), .rd(s_rd), .out_tag(s_out_tag), .illegal(s_illegal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference: operands interpreted as plain integers, results from the op rules.
   function automatic exp_t model(input logic [3:0] o, input logic [31:0] a,
                                  input logic [31:0] b, input logic [4:0] t);
      exp_t   m;
      longint sa;
      longint sb;
      longint ua;
      longint ub;
      ua = longint'(a);
      ub = longint'(b);
      sa = a[31] ? ua - 64'sh1_0000_0000 : ua;
      sb = b[31] ? ub - 64'sh1_0000_0000 : ub;
      m.tag = t;
      m.ill = 1'b0;
      m.rd  = '0;
      case (o)
         4'd0: m.rd = {31'd0, sa < sb};
         4'd1: m.rd = {31'd0, ua < ub};
         4'd2: m.rd = {31'd0, ua == ub};
         4'd3: m.rd = {31'd0, ua != ub};
         4'd4: m.rd = {31'd0, sa >= sb};
         4'd5: m.rd = {31'd0, ua >= ub};
         4'd6: m.rd = (sb < sa) ? b : a;
         4'd7: m.rd = (sb > sa) ? b : a;
         4'd8: m.rd = (ub < ua) ? b : a;
         4'd9: m.rd = (ub > ua) ? b : a;
         default: m.ill = 1'b1;
      endcase
      return m;
   endfunction

   task automatic check_out(input string nm);
      exp_t e;
      chk({nm, "_expected_output"}, q.size() != 0, 1);
      if (q.size() != 0) begin
         e = q.pop_front();
         chk({nm, "_rd"}, rd, e.rd);
         chk({nm, "_tag"}, out_tag, e.tag);
         chk({nm, "_illegal"}, illegal, e.ill);
      end
   endtask

   // Called at posedge+1 with the pipe empty; returns at posedge+1 with the pipe drained.
   task automatic send_check(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] t, input logic [31:0] er, input logic ei,
                             input string nm);
      in_valid = 1'b1; op = o; rs1 = a; rs2 = b; in_tag = t; out_ready = 1'b1;
      #1 chk({nm, "_in_ready"}, in_ready, 1);
      @(posedge clk);
      #1 in_valid = 1'b0; op = 4'($urandom); rs1 = $urandom; rs2 = $urandom;
      for (int k = 1; k <= LAT; k++) begin
         if (k > 1) begin
            @(posedge clk);
            #1;
         end
         #1 chk({nm, "_out_valid"}, out_valid, k == LAT);
      end
      chk({nm, "_rd"}, rd, er);
      chk({nm, "_tag"}, out_tag, t);
      chk({nm, "_illegal"}, illegal, ei);
      @(posedge clk);
      #1;
   endtask

   initial begin
      vt[0] = '{4'd1,  32'hFFFF_FFFF, 32'd1, 32'd0,         1'b0};
      vt[1] = '{4'd0,  32'hFFFF_FFFF, 32'd1, 32'd1,         1'b0};
      vt[2] = '{4'd1,  32'd1,         32'd2, 32'd1,         1'b0};
      vt[3] = '{4'd1,  32'd2,         32'd1, 32'd0,         1'b0};
      vt[4] = '{4'd1,  32'd1,         32'd1, 32'd0,         1'b0};
      vt[5] = '{4'd6,  32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFE, 1'b0};
      vt[6] = '{4'd9,  32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFE, 1'b0};
      vt[7] = '{4'd8,  32'hFFFF_FFFE, 32'd3, 32'd3,         1'b0};
      vt[8] = '{4'd12, 32'd5,         32'd6, 32'd0,         1'b1};
      vt[9] = '{4'd7,  32'hFFFF_FFFE, 32'd3, 32'd3,         1'b0};
      bp_tag = '{0, 0, 1, 1, 1, 1, 2, 3, 0};

      rst = 1'b1; in_valid = 1'b0; op = '0; rs1 = '0; rs2 = '0; in_tag = '0; out_ready = 1'b1;
      s_in_valid = 1'b0; s_op = '0; s_rs1 = '0; s_rs2 = '0; s_in_tag = '0; s_out_ready = 1'b1;
      #2;
      chk("reset_out_valid", out_valid, 0);
      chk("reset_rd", rd, 0);
      chk("reset_tag", out_tag, 0);
      chk("reset_illegal", illegal, 0);
      chk("reset_in_ready", in_ready, 1);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;

      for (int i = 0; i < 10; i++) begin
         send_check(vt[i].op, vt[i].a, vt[i].b, 5'(i + 3), vt[i].exp_rd, vt[i].exp_ill,
                    $sformatf("vec%0d", i));
      end

      // Back-to-back stream of 8 random ops, tags 0..7.
      for (int c = 0; c < 8 + LAT + 1; c++) begin
         out_ready = 1'b1;
         in_valid  = (c < 8);
         op = 4'($urandom_range(0, 15)); rs1 = $urandom; rs2 = $urandom; in_tag = 5'(c);
         #1;
         chk("b2b_in_ready", in_ready, 1);
         chk("b2b_out_valid", out_valid, (c >= LAT) && (c < 8 + LAT));
         if (out_valid) begin
            chk("b2b_order", out_tag, 5'(c - LAT));
            check_out("b2b");
         end
         if (in_valid && in_ready) q.push_back(model(op, rs1, rs2, in_tag));
         @(posedge clk);
         #1;
      end

      // Backpressure: tags 1..3, output stalled for 3 cycles once tag 1 arrives.
      begin
         int idx = 1;
         for (int c = 0; c < 9; c++) begin
            out_ready = !(c >= 2 && c <= 4);
            in_valid  = (idx <= 3);
            op = 4'd7; rs1 = 32'(idx * 100); rs2 = 32'd0; in_tag = 5'(idx);
            #1;
            chk("bp_in_ready", in_ready, !(c >= 2 && c <= 4));
            chk("bp_out_valid", out_valid, bp_tag[c] != 0);
            if (bp_tag[c] != 0) begin
               chk("bp_tag", out_tag, 5'(bp_tag[c]));
               chk("bp_rd", rd, 32'(bp_tag[c] * 100));
            end
            if (in_valid && in_ready) idx++;
            @(posedge clk);
            #1;
         end
      end

      // Asynchronous reset with two ops in flight.
      out_ready = 1'b1; in_valid = 1'b1; op = 4'd7; rs1 = 32'd55; rs2 = 32'd1; in_tag = 5'd10;
      @(posedge clk);
      #1 in_tag = 5'd11;
      @(posedge clk);
      #1 in_valid = 1'b0;
      #1 chk("pre_reset_out_valid", out_valid, 1);
      #2 rst = 1'b1;
      #1;
      chk("mid_reset_out_valid", out_valid, 0);
      chk("mid_reset_rd", rd, 0);
      chk("mid_reset_tag", out_tag, 0);
      chk("mid_reset_in_ready", in_ready, 1);
      @(posedge clk);
      #3 rst = 1'b0;
      @(posedge clk);
      #1;
      send_check(4'd2, 32'd9, 32'd9, 5'd20, 32'd1, 1'b0, "post_reset");
      #1 chk("post_reset_no_stale", out_valid, 0);

      // WIDTH=8, LAT=1 instance, two ops back to back.
      @(posedge clk);
      #1 s_in_valid = 1'b1; s_op = 4'd0; s_rs1 = 8'h80; s_rs2 = 8'h7F; s_in_tag = 5'd3;
      #1 chk("w8_in_ready", s_in_ready, 1);
      chk("w8_idle", s_out_valid, 0);
      @(posedge clk);
      #1 s_op = 4'd1; s_in_tag = 5'd4;
      #1;
      chk("w8_slt_valid", s_out_valid, 1);
      chk("w8_slt_rd", s_rd, 8'h01);
      chk("w8_slt_tag", s_out_tag, 3);
      @(posedge clk);
      #1 s_in_valid = 1'b0;
      #1;
      chk("w8_sltu_valid", s_out_valid, 1);
      chk("w8_sltu_rd", s_rd, 8'h00);
      chk("w8_sltu_tag", s_out_tag, 4);
      @(posedge clk);
      #2 chk("w8_drained", s_out_valid, 0);
      @(posedge clk);
      #1;

      // Randomized traffic with random backpressure.
      begin
         logic        pend = 1'b0;
         logic        pv = 1'b0;
         logic        pr = 1'b0;
         logic [31:0] prd = '0;
         logic [4:0]  ptag = '0;
         logic        pill = 1'b0;
         for (int c = 0; c < 400 + LAT + 2; c++) begin
            if (c < 400) begin
               if (!pend && $urandom_range(0, 99) < 70) begin
                  pend = 1'b1;
                  op   = 4'($urandom_range(0, 15));
                  rs1  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
                  rs2  = ($urandom_range(0, 3) == 0) ? rs1 : $urandom;
                  if ($urandom_range(0, 3) == 0) rs2 = rs2 ^ 32'h8000_0000;
                  in_tag = 5'($urandom);
               end
               out_ready = ($urandom_range(0, 99) < 60);
            end else begin
               pend = 1'b0;
               out_ready = 1'b1;
            end
            in_valid = pend;
            #1;
            chk("rnd_in_ready", in_ready, !out_valid || out_ready);
            if (pv && !pr) begin
               chk("rnd_hold_valid", out_valid, 1);
               chk("rnd_hold_rd", rd, prd);
               chk("rnd_hold_tag", out_tag, ptag);
               chk("rnd_hold_illegal", illegal, pill);
            end
            if (out_valid && out_ready) check_out("rnd");
            if (in_valid && in_ready) begin
               q.push_back(model(op, rs1, rs2, in_tag));
               pend = 1'b0;
            end
            pv = out_valid; pr = out_ready; prd = rd; ptag = out_tag; pill = illegal;
            @(posedge clk);
            #1;
         end
         in_valid = 1'b0;
         #1 chk("rnd_drained", out_valid, 0);
         chk("rnd_scoreboard_empty", q.size(), 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
